text_char_renderer: RTL and testbench

- Text-mode pixel pipeline wrapped around font_rom.
- Scans the pixel stream from the video timing generator and fetches {attr, char} from the text RAM.
- Drives char_num/line_num/font_num into font_rom, serialises the returned 8-bit glyph row into 4-bit colour indices, and adds cursor and blink.
- Sits between the timing generator and the palette/DAC stage.

---
 rtl/text_char_renderer.sv | 173 +++++++++++++++++
 tb/tb_text_char_renderer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/text_char_renderer.sv
// Text-mode pixel pipeline: scans the timing generator's pixel stream, fetches {attr, char}
// from text RAM, drives the font ROM and turns glyph rows into 4-bit colour indices.
module text_char_renderer #(
    parameter int COLS   = 80,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        font_sel,
    input  logic              de_in,
    input  logic              hsync_in,
    input  logic              vsync_in,
    output logic [ADDR_W-1:0] text_addr,
    input  logic [15:0]       text_data,
    output logic [1:0]        font_num,
    output logic [7:0]        char_num,
    output logic [3:0]        line_num,
    input  logic [7:0]        font_data,
    input  logic              cursor_en,
    input  logic [6:0]        cursor_col,
    input  logic [4:0]        cursor_row,
    output logic [3:0]        pix_color,
    output logic              de_out,
    output logic              hsync_out,
    output logic              vsync_out
);

    localparam logic [ADDR_W-1:0] COLS_A = ADDR_W'(COLS);

    // Scan counters and the font latched at frame start
    logic [2:0] xpix_q, xpix_d;
    logic [6:0] col_q, col_d;
    logic [3:0] cline_q, cline_d;
    logic [4:0] row_q, row_d;
    logic [4:0] frame_q, frame_d;
    logic [1:0] font_q, font_d;
    logic       de_prev_q;
    logic       vsync_prev_q;

    logic       vs_rise;
    logic       de_fall;
    logic [3:0] h_last;
    logic       cursor_hit;

    // Stage 1 captures at the end of t, stage 2 at the end of t+1, stage 3 at the end of t+2
    logic [2:0] xpix_s1_q, xpix_s2_q;
    logic       hit_s1_q, hit_s2_q;
    logic       blink_s1_q, blink_s2_q;
    logic [3:0] line_s1_q;
    logic [7:0] attr_s2_q;
    logic [2:0] sync_s1_q, sync_s2_q, sync_s3_q;
    logic [3:0] pix_q, pix_d;
    logic       glyph_bit;

    assign vs_rise = vsync_in & ~vsync_prev_q;
    assign de_fall = ~de_in & de_prev_q;

    always_comb begin
        case (font_q)
            2'd0:    h_last = 4'd7;
            2'd1:    h_last = 4'd13;
            default: h_last = 4'd15;
        endcase
    end

    always_comb begin
        xpix_d  = xpix_q;
        col_d   = col_q;
        cline_d = cline_q;
        row_d   = row_q;
        frame_d = frame_q;
        font_d  = font_q;
        if (vs_rise) begin
            xpix_d  = 3'd0;
            col_d   = 7'd0;
            cline_d = 4'd0;
            row_d   = 5'd0;
            frame_d = frame_q + 5'd1;
            font_d  = (font_sel == 2'd3) ? 2'd2 : font_sel;
        end else if (de_fall) begin
            xpix_d = 3'd0;
            col_d  = 7'd0;
            if (cline_q >= h_last) begin
                cline_d = 4'd0;
                row_d   = row_q + 5'd1;
            end else begin
                cline_d = cline_q + 4'd1;
            end
        end else if (de_in) begin
            xpix_d = xpix_q + 3'd1;
            if (xpix_q == 3'd7) begin
                col_d = col_q + 7'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xpix_q       <= 3'd0;
            col_q        <= 7'd0;
            cline_q      <= 4'd0;
            row_q        <= 5'd0;
            frame_q      <= 5'd0;
            font_q       <= 2'd0;
            de_prev_q    <= 1'b0;
            vsync_prev_q <= 1'b0;
        end else begin
            xpix_q       <= xpix_d;
            col_q        <= col_d;
            cline_q      <= cline_d;
            row_q        <= row_d;
            frame_q      <= frame_d;
            font_q       <= font_d;
            de_prev_q    <= de_in;
            vsync_prev_q <= vsync_in;
        end
    end

    assign text_addr  = ADDR_W'(row_q) * COLS_A + ADDR_W'(col_q);
    assign cursor_hit = cursor_en && (col_q == cursor_col) && (row_q == cursor_row) &&
                        (cline_q >= (h_last - 4'd1)) && frame_q[3];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xpix_s1_q  <= 3'd0;
            xpix_s2_q  <= 3'd0;
            hit_s1_q   <= 1'b0;
            hit_s2_q   <= 1'b0;
            blink_s1_q <= 1'b0;
            blink_s2_q <= 1'b0;
            line_s1_q  <= 4'd0;
            attr_s2_q  <= 8'd0;
            sync_s1_q  <= 3'd0;
            sync_s2_q  <= 3'd0;
            sync_s3_q  <= 3'd0;
            pix_q      <= 4'd0;
        end else begin
            xpix_s1_q  <= xpix_q;
            xpix_s2_q  <= xpix_s1_q;
            hit_s1_q   <= cursor_hit;
            hit_s2_q   <= hit_s1_q;
            blink_s1_q <= frame_q[4];
            blink_s2_q <= blink_s1_q;
            line_s1_q  <= cline_q;
            attr_s2_q  <= text_data[15:8];
            sync_s1_q  <= {de_in, hsync_in, vsync_in};
            sync_s2_q  <= sync_s1_q;
            sync_s3_q  <= sync_s2_q;
            pix_q      <= pix_d;
        end
    end

    // Blink hides only the glyph; the cursor stays visible through the off phase
    always_comb begin
        glyph_bit = font_data[3'd7 - xpix_s2_q];
        if (attr_s2_q[7] && !blink_s2_q) begin
            glyph_bit = 1'b0;
        end
        pix_d = 4'd0;
        if (sync_s2_q[2]) begin
            pix_d = (glyph_bit || hit_s2_q) ? attr_s2_q[3:0] : {1'b0, attr_s2_q[6:4]};
        end
    end

    assign char_num  = text_data[7:0];
    assign line_num  = line_s1_q;
    assign font_num  = font_q;
    assign pix_color = pix_q;
    assign de_out    = sync_s3_q[2];
    assign hsync_out = sync_s3_q[1];
    assign vsync_out = sync_s3_q[0];

endmodule

// File: tb/tb_text_char_renderer.sv
// Bench for text_char_renderer: text RAM and font ROM models, a frame/line level screen
// model that predicts every output cycle, and a due-cycle stamped expected queue.
module tb_text_char_renderer;

    localparam int COLS   = 80;
    localparam int ADDR_W = 12;
    localparam int EW     = 39;

    logic              clk;
    logic              rst_n;
    logic [1:0]        font_sel;
    logic              de_in;
    logic              hsync_in;
    logic              vsync_in;
    logic [ADDR_W-1:0] text_addr;
    logic [15:0]       text_data;
    logic [1:0]        font_num;
    logic [7:0]        char_num;
    logic [3:0]        line_num;
    logic [7:0]        font_data;
    logic              cursor_en;
    logic [6:0]        cursor_col;
    logic [4:0]        cursor_row;
    logic [3:0]        pix_color;
    logic              de_out;
    logic              hsync_out;
    logic              vsync_out;

    text_char_renderer #(.COLS(COLS), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .font_sel(font_sel), .de_in(de_in),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .text_addr(text_addr),
        .text_data(text_data), .font_num(font_num), .char_num(char_num),
        .line_num(line_num), .font_data(font_data), .cursor_en(cursor_en),
        .cursor_col(cursor_col), .cursor_row(cursor_row), .pix_color(pix_color),
        .de_out(de_out), .hsync_out(hsync_out), .vsync_out(vsync_out)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc_n = 0;
    always @(posedge clk) cyc_n++;

    // Memory models
    logic [15:0] text_ram [0:4095];
    logic        const_mode;

    function automatic logic [7:0] font_fn(input logic [1:0] f, input logic [7:0] c,
                                           input logic [3:0] l);
        if (const_mode) return 8'hC3;
        return 8'(c * 8'd7) ^ {l, ~l} ^ {f, f, f, f};
    endfunction

    always @(posedge clk) text_data <= text_ram[text_addr];
    always @(posedge clk) font_data <= font_fn(font_num, char_num, line_num);

    // Checker and scoreboard
    int checks = 0;
    int failures = 0;
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] mon_e;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            while (exp_q.size() > 0 && int'(exp_q[0][EW-1:7]) <= cyc_n) begin
                mon_e = exp_q.pop_front();
                check_eq("pix", 32'(pix_color), 32'(mon_e[3:0]));
                check_eq("sync", 32'({de_out, hsync_out, vsync_out}), 32'(mon_e[6:4]));
            end
        end
    end

    // Screen model
    int         m_row, m_line, m_frame;
    logic [1:0] m_font;

    function automatic int char_h();
        return (m_font == 2'd0) ? 8 : (m_font == 2'd1) ? 14 : 16;
    endfunction

    function automatic logic [3:0] exp_pix(input int col, input int x);
        logic [15:0] w;
        logic [7:0]  gl;
        logic        g;
        logic        hit;
        w   = text_ram[(m_row * COLS + col) % 4096];
        gl  = font_fn(m_font, w[7:0], 4'(m_line));
        g   = gl[7 - x];
        if (w[15] && ((m_frame & 16) == 0)) g = 1'b0;
        hit = cursor_en && (col == int'(cursor_col)) && (m_row == int'(cursor_row)) &&
              (m_line >= char_h() - 2) && ((m_frame & 8) != 0);
        return (g || hit) ? w[11:8] : {1'b0, w[14:12]};
    endfunction

    // Drivers
    task automatic drive_cyc(input logic de, input logic hs, input logic vs, input logic [3:0] pix);
        @(posedge clk);
        #1;
        de_in    = de;
        hsync_in = hs;
        vsync_in = vs;
        exp_q.push_back({32'(cyc_n + 3), de, hs, vs, de ? pix : 4'd0});
    endtask

    task automatic pix_cyc(input int col, input int x, input int p);
        logic [3:0] e;
        int a;
        e = exp_pix(col, x);
        a = (m_row * COLS + col) % 4096;
        drive_cyc(1'b1, 1'b0, 1'b0, e);
        #1;
        check_eq("text_addr", 32'(text_addr), 32'(a));
        if (p == 1) check_eq("line_num", 32'(line_num), 32'(m_line));
    endtask

    task automatic do_line(input int npix);
        for (int p = 0; p < npix; p++) pix_cyc(p / 8, p % 8, p);
        drive_cyc(1'b0, 1'b0, 1'b0, 4'd0);
        drive_cyc(1'b0, 1'b1, 1'b0, 4'd0);
        drive_cyc(1'b0, 1'b1, 1'b0, 4'd0);
        drive_cyc(1'b0, 1'b0, 1'b0, 4'd0);
        if (m_line == char_h() - 1) begin
            m_line = 0;
            m_row  = (m_row + 1) % 32;
        end else begin
            m_line++;
        end
    endtask

    task automatic frame_start(input logic [1:0] fs);
        font_sel = fs;
        repeat (3) drive_cyc(1'b0, 1'b0, 1'b1, 4'd0);
        repeat (2) drive_cyc(1'b0, 1'b0, 1'b0, 4'd0);
        m_font  = (fs == 2'd3) ? 2'd2 : fs;
        m_frame = (m_frame + 1) % 32;
        m_row   = 0;
        m_line  = 0;
        #1;
        check_eq("font_num", 32'(font_num), 32'(m_font));
    endtask

    initial begin
        rst_n = 1'b0; font_sel = 2'd1; de_in = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;
        cursor_en = 1'b0; cursor_col = 7'd0; cursor_row = 5'd0; const_mode = 1'b1;
        m_row = 0; m_line = 0; m_frame = 0; m_font = 2'd0;
        for (int i = 0; i < 4096; i++) text_ram[i] = 16'($urandom_range(0, 65535));
        text_ram[0] = 16'h1E41;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_pix", 32'(pix_color), 32'd0);
        check_eq("rst_sync", 32'({de_out, hsync_out, vsync_out}), 32'd0);
        check_eq("rst_addr", 32'(text_addr), 32'd0);
        check_eq("rst_font", 32'(font_num), 32'd0);
        check_eq("rst_line", 32'(line_num), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) drive_cyc(1'b0, 1'b0, 1'b0, 4'd0);

        // First frame before any vsync: font 0 regardless of font_sel; E,E,1,1,1,1,E,E
        check_eq("font_num_pre", 32'(font_num), 32'd0);
        do_line(16);
        frame_start(2'd1);
        do_line(16);

        // 8x8 font, hashed glyphs: line stepping, row stepping and row wrap at 32
        frame_start(2'd0);
        const_mode = 1'b0;
        repeat (9) do_line(16);
        repeat (255) do_line(8);

        // Reach frame_cnt[3] = 1 using font_sel 3 (treated as 2)
        while (m_frame < 8) frame_start(2'd3);
        const_mode  = 1'b1;
        text_ram[0] = 16'h1E41;
        cursor_en   = 1'b1;
        repeat (16) do_line(16);
        cursor_en = 1'b0;

        // Blink: off phase, then on phase after 16 more frames
        frame_start(2'd2);
        text_ram[0] = 16'h9F41;
        do_line(8);
        repeat (16) frame_start(2'd2);
        do_line(8);

        // Reset in the middle of a line (row 0, line 1, column 1)
        for (int p = 0; p < 12; p++) pix_cyc(p / 8, p % 8, p);
        @(posedge clk);
        #1 rst_n = 1'b0;
        exp_q.delete();
        #1;
        check_eq("mid_rst_pix", 32'(pix_color), 32'd0);
        check_eq("mid_rst_de", 32'(de_out), 32'd0);
        check_eq("mid_rst_addr", 32'(text_addr), 32'd0);
        check_eq("mid_rst_line", 32'(line_num), 32'd0);
        check_eq("mid_rst_font", 32'(font_num), 32'd0);
        de_in = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        m_row = 0; m_line = 0; m_frame = 0; m_font = 2'd0;
        text_ram[0] = 16'h1E41;
        repeat (3) drive_cyc(1'b0, 1'b0, 1'b0, 4'd0);
        do_line(16);
        check_eq("font_after_rst", 32'(font_num), 32'd0);

        repeat (4) drive_cyc(1'b0, 1'b0, 1'b0, 4'd0);
        repeat (5) @(posedge clk);
        #1;
        check_eq("drain", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
